// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver that assembles NUM_BYTES bytes into one frame
// presented on a valid/ready handshake, with false-start, framing, timeout and overrun detection.
module uart_rx_frame #(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int BAUD         = 9600,
    parameter int NUM_BYTES    = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             rx_serial,
    output logic [8*NUM_BYTES-1:0]           frame_data,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic [$clog2(NUM_BYTES+1)-1:0]   byte_count,
    output logic                             busy,
    output logic                             framing_error,
    output logic                             timeout_error,
    output logic                             overrun_error
);
    localparam int CPB    = CLOCK_FREQ / BAUD;
    localparam int TO_CYC = TIMEOUT_BITS * CPB;
    localparam int CW     = $clog2(CPB);
    localparam int GW     = $clog2(TO_CYC + 1);
    localparam int BCW    = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                   state;
    logic [1:0]               sync;
    logic                     rx_s;
    logic [CW-1:0]            clk_cnt;
    logic [2:0]               bit_idx;
    logic [GW-1:0]            gap;
    logic [7:0]               shift;
    logic [8*NUM_BYTES-1:0]   asm_reg;
    logic [8*NUM_BYTES-1:0]   asm_next;

    assign rx_s = sync[1];
    assign busy = (state != IDLE) || (byte_count != '0);

    // Slot 0 is the most significant byte, so the first byte received lands on top.
    always_comb begin
        asm_next = asm_reg;
        for (int i = 0; i < NUM_BYTES; i++)
            if (byte_count == BCW'(i)) asm_next[8*(NUM_BYTES-1-i) +: 8] = shift;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sync          <= 2'b11;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            gap           <= '0;
            shift         <= '0;
            asm_reg       <= '0;
            byte_count    <= '0;
            frame_data    <= '0;
            frame_valid   <= 1'b0;
            framing_error <= 1'b0;
            timeout_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            sync          <= {sync[0], rx_serial};
            framing_error <= 1'b0;
            timeout_error <= 1'b0;
            overrun_error <= 1'b0;
            if (frame_valid && frame_ready) frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                        gap     <= '0;
                    end else if (byte_count != '0) begin
                        if (gap == GW'(TO_CYC - 1)) begin
                            timeout_error <= 1'b1;
                            byte_count    <= '0;
                            gap           <= '0;
                        end else begin
                            gap <= gap + 1'b1;
                        end
                    end
                end
                START: begin
                    if (clk_cnt == CW'(CPB/2 - 1)) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CW'(CPB - 1)) begin
                        clk_cnt <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == CW'(CPB - 1)) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            framing_error <= 1'b1;
                            byte_count    <= '0;
                            state         <= BREAK;
                        end else begin
                            state <= IDLE;
                            if (byte_count == BCW'(NUM_BYTES - 1)) begin
                                byte_count <= '0;
                                // A frame still waiting for its consumer keeps priority over the new one.
                                if (!frame_valid || frame_ready) begin
                                    frame_data  <= asm_next;
                                    frame_valid <= 1'b1;
                                end else begin
                                    overrun_error <= 1'b1;
                                end
                            end else begin
                                byte_count <= byte_count + 1'b1;
                                asm_reg    <= asm_next;
                            end
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
